// File: rtl/opl3_pkg.sv
// rtl/opl3_pkg.sv - shared constants, types and helpers for the DAC output path
package opl3_pkg;

  localparam int DAC_OUTPUT_WIDTH = 16;
  localparam int I2S_SLOT_WIDTH   = 32;
  localparam int I2S_BCLK_DIV     = 4;

  // Where the next I2S frame takes its stereo sample from.
  typedef enum logic [1:0] {
    LOAD_BYPASS  = 2'd0,
    LOAD_PENDING = 2'd1,
    LOAD_REPEAT  = 2'd2
  } load_src_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - divides clk down to the I2S bit clock and flags its edges
module i2s_bclk_gen
  import opl3_pkg::*;
#(
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CNT_WIDTH = cnt_width(BCLK_DIV);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BCLK_DIV - 1);

  if (BCLK_DIV < 1) begin : g_div_chk
    $error("i2s_bclk_gen: BCLK_DIV must be at least 1");
  end

  logic [CNT_WIDTH-1:0] div_cnt;
  logic                 terminal;

  assign terminal = (div_cnt == LAST_CNT);
  // Edge strobes are decoded from the current bclk level so they line up with the toggle.
  assign rise_evt = terminal && !bclk;
  assign fall_evt = terminal && bclk;

  // Half-period counter; bclk toggles each time it reaches terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      bclk    <= !bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - one-sample buffered Philips I2S serializer with underrun/overrun status
module i2s_tx
  import opl3_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DAC_OUTPUT_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter int BCLK_DIV     = I2S_BCLK_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    clear_flags,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_sdata,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int FRAME_WIDTH   = 2 * SLOT_WIDTH;
  localparam int BIT_CNT_WIDTH = cnt_width(FRAME_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT       = BIT_CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] RIGHT_LEAD_BIT = BIT_CNT_WIDTH'(SLOT_WIDTH - 1);

  if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_slot_chk
    $error("i2s_tx: SLOT_WIDTH must be at least SAMPLE_WIDTH");
  end

  logic                     bclk_rise;
  logic                     fall_evt;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic [BIT_CNT_WIDTH-1:0] next_bit;
  logic [FRAME_WIDTH-1:0]   frame_reg;
  logic [FRAME_WIDTH-1:0]   load_frame;
  logic [FRAME_WIDTH-1:0]   next_frame;
  logic [SAMPLE_WIDTH-1:0]  hold_l;
  logic [SAMPLE_WIDTH-1:0]  hold_r;
  logic [SAMPLE_WIDTH-1:0]  load_l;
  logic [SAMPLE_WIDTH-1:0]  load_r;
  logic                     pending;
  logic                     load;
  logic                     underrun_set;
  logic                     overrun_set;
  load_src_t                load_src;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (i2s_bclk),
    .rise_evt (bclk_rise),
    .fall_evt (fall_evt)
  );

  // The divider only ever reports one edge per toggle.
  a_one_edge : assert property (@(posedge clk) disable iff (reset) !(bclk_rise && fall_evt));

  // Next bit position, load decision, load source and the frame word built from it.
  always_comb begin
    next_bit     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    load         = fall_evt && (next_bit == '0);
    load_src     = LOAD_REPEAT;
    if (sample_valid) begin
      load_src = LOAD_BYPASS;
    end else if (pending) begin
      load_src = LOAD_PENDING;
    end
    load_l       = (load_src == LOAD_BYPASS) ? sample_l : hold_l;
    load_r       = (load_src == LOAD_BYPASS) ? sample_r : hold_r;
    load_frame   = '0;
    load_frame[FRAME_WIDTH-1 -: SAMPLE_WIDTH] = load_l;
    load_frame[SLOT_WIDTH-1 -: SAMPLE_WIDTH]  = load_r;
    next_frame   = load ? load_frame : {frame_reg[FRAME_WIDTH-2:0], 1'b0};
    underrun_set = load && (load_src == LOAD_REPEAT);
    overrun_set  = sample_valid && pending;
  end

  // Bit counter, word select and frame shifter advance on each BCLK falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= LAST_BIT;
      i2s_lrck    <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_reg   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (fall_evt) begin
        bit_cnt   <= next_bit;
        frame_reg <= next_frame;
        i2s_sdata <= next_frame[FRAME_WIDTH-1];
        // LRCK switches one bit ahead of each slot's MSB.
        if (next_bit == RIGHT_LEAD_BIT) begin
          i2s_lrck <= 1'b1;
        end else if (next_bit == LAST_BIT) begin
          i2s_lrck <= 1'b0;
        end
      end
    end
  end

  // One-deep sample buffer; the most recent sample always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l  <= '0;
      hold_r  <= '0;
      pending <= 1'b0;
    end else if (sample_valid) begin
      hold_l  <= sample_l;
      hold_r  <= sample_r;
      pending <= !load;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  // Sticky status; a set event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (clear_flags) begin
        underrun <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - self-checking bench for i2s_tx
module tb_i2s_tx;

  localparam int AW = 16;
  localparam int AS = 16;
  localparam int AD = 1;
  localparam int BWID = 24;
  localparam int BS = 32;
  localparam int BD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1, sv_a = 1'b0, clr_a = 1'b0;
  logic [AW-1:0] l_a = '0, r_a = '0;
  logic          bclk_a, lrck_a, sd_a, fs_a, ur_a, or_a;
  logic            rst_b = 1'b1, sv_b = 1'b0, clr_b = 1'b0;
  logic [BWID-1:0] l_b = '0, r_b = '0;
  logic            bclk_b, lrck_b, sd_b, fs_b, ur_b, or_b;

  i2s_tx #(.SAMPLE_WIDTH(AW), .SLOT_WIDTH(AS), .BCLK_DIV(AD)) dut_a (
    .clk(clk), .reset(rst_a), .sample_valid(sv_a), .sample_l(l_a), .sample_r(r_a),
    .clear_flags(clr_a), .i2s_bclk(bclk_a), .i2s_lrck(lrck_a), .i2s_sdata(sd_a),
    .frame_start(fs_a), .underrun(ur_a), .overrun(or_a));

  i2s_tx #(.SAMPLE_WIDTH(BWID), .SLOT_WIDTH(BS), .BCLK_DIV(BD)) dut_b (
    .clk(clk), .reset(rst_b), .sample_valid(sv_b), .sample_l(l_b), .sample_r(r_b),
    .clear_flags(clr_b), .i2s_bclk(bclk_b), .i2s_lrck(lrck_b), .i2s_sdata(sd_b),
    .frame_start(fs_b), .underrun(ur_b), .overrun(or_b));

  int checks = 0;
  int errors = 0;
  int cyc_a, cyc_b;

  always @(posedge clk) cyc_a <= rst_a ? 0 : cyc_a + 1;
  always @(posedge clk) cyc_b <= rst_b ? 0 : cyc_b + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- I2S decoder: samples sdata on BCLK rise, frames on LRCK ----------------
  logic        p1 [2], p2 [2], lfull [2], rfull [2], bl [2];
  logic [31:0] word [2], lw [2], rw [2];
  int          nb [2];
  logic [31:0] fa_l[$], fa_r[$], fb_l[$], fb_r[$];

  task automatic dec_rise(input int i, input logic sd, input logic lr, input int slot);
    if (p1[i] != p2[i]) begin
      if (p2[i] == 1'b0) begin
        lw[i] = word[i];
        lfull[i] = (nb[i] == slot);
      end else begin
        rw[i] = word[i];
        rfull[i] = (nb[i] == slot);
        if (lfull[i] && rfull[i]) begin
          if (i == 0) begin fa_l.push_back(lw[0]); fa_r.push_back(rw[0]); end
          else        begin fb_l.push_back(lw[1]); fb_r.push_back(rw[1]); end
        end
        lfull[i] = 1'b0;
        rfull[i] = 1'b0;
      end
      word[i] = '0;
      nb[i] = 0;
    end
    word[i] = {word[i][30:0], sd};
    nb[i]++;
    p2[i] = p1[i];
    p1[i] = lr;
  endtask

  task automatic dec_reset(input int i);
    p1[i] = 1'b1; p2[i] = 1'b1; nb[i] = 0; word[i] = '0;
    lfull[i] = 1'b0; rfull[i] = 1'b0; bl[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_a) begin
      dec_reset(0);
      fa_l.delete(); fa_r.delete();
    end else begin
      if (bclk_a && !bl[0]) dec_rise(0, sd_a, lrck_a, AS);
      bl[0] = bclk_a;
    end
  end

  int   lrfall_b[$], fsb[$];
  logic lrb_last;
  always @(negedge clk) begin
    if (rst_b) begin
      dec_reset(1);
      lrb_last = 1'b0;
    end else begin
      if (bclk_b && !bl[1]) dec_rise(1, sd_b, lrck_b, BS);
      bl[1] = bclk_b;
      if (lrb_last && !lrck_b) lrfall_b.push_back(cyc_b);
      if (fs_b) fsb.push_back(cyc_b);
      lrb_last = lrck_b;
    end
  end

  // ---------------- reference model for instance A (interval based) ----------------
  int            ev_edge[$];
  logic [AW-1:0] ev_l[$], ev_r[$];
  int            clr_edge[$];

  function automatic int ld(input int j);
    return 2 * AD * (1 + 2 * AS * j);
  endfunction

  // Index of the load that consumes a sample presented at edge x.
  function automatic int interval_of(input int x);
    int p = 4 * AD * AS;
    if (x <= ld(0)) return 0;
    return (x - ld(0) + p - 1) / p;
  endfunction

  function automatic int count_in(input int k);
    int c = 0;
    foreach (ev_edge[i]) if (interval_of(ev_edge[i]) == k) c++;
    return c;
  endfunction

  function automatic logic [2*AW-1:0] model_frame(input int j);
    logic [2*AW-1:0] cur = '0;
    for (int k = 0; k <= j; k++)
      foreach (ev_edge[i]) if (interval_of(ev_edge[i]) == k) cur = {ev_l[i], ev_r[i]};
    return cur;
  endfunction

  function automatic logic model_flag(input logic ovr, input int t);
    int last_set = -1;
    int last_clr = -1;
    if (!ovr) begin
      for (int k = 0; ld(k) <= t; k++) if (count_in(k) == 0) last_set = ld(k);
    end else begin
      foreach (ev_edge[i])
        if (ev_edge[i] <= t)
          for (int m = 0; m < i; m++)
            if (interval_of(ev_edge[m]) == interval_of(ev_edge[i]) && ev_edge[i] > last_set)
              last_set = ev_edge[i];
    end
    foreach (clr_edge[i]) if (clr_edge[i] <= t && clr_edge[i] > last_clr) last_clr = clr_edge[i];
    return (last_set >= 0) && (last_set >= last_clr);
  endfunction

  // Drive a one-cycle strobe sampled by instance A at edge e.
  task automatic pulse(input int e, input logic is_clr, input logic [AW-1:0] l, input logic [AW-1:0] r);
    while (cyc_a < e - 1) @(negedge clk);
    if (is_clr) begin
      clr_a = 1'b1;
      clr_edge.push_back(e);
    end else begin
      sv_a = 1'b1; l_a = l; r_a = r;
      ev_edge.push_back(e); ev_l.push_back(l); ev_r.push_back(r);
    end
    @(negedge clk);
    sv_a = 1'b0;
    clr_a = 1'b0;
  endtask

  typedef struct {
    int n; int off_a; int off_b; int clr_off;
    logic [AW-1:0] la, ra, lb, rb, xl, xr;
    logic xu, xo;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*AW-1:0] mf;
    //            n off_a off_b clr  la        ra        lb        rb        xl        xr        xu    xo
    tbl[0]  = '{1,  1, 0, -1, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000, 16'h8001, 16'h7FFE, 1'b0, 1'b0};
    tbl[1]  = '{1, 10, 0, -1, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000, 16'h8001, 16'h7FFE, 1'b0, 1'b0};
    tbl[2]  = '{1, 30, 0, -1, 16'h00FF, 16'h1234, 16'h0000, 16'h0000, 16'h00FF, 16'h1234, 1'b0, 1'b0};
    tbl[3]  = '{0,  0, 0, -1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h1234, 1'b1, 1'b0};
    tbl[4]  = '{0,  0, 0, -1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h1234, 1'b1, 1'b0};
    tbl[5]  = '{1, 20, 0, 40, 16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 16'h5555, 16'hAAAA, 1'b0, 1'b0};
    tbl[6]  = '{2, 50, 10, -1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1'b0, 1'b1};
    tbl[7]  = '{1,  0, 0, 40, 16'hAAAA, 16'h5A5A, 16'h0000, 16'h0000, 16'hAAAA, 16'h5A5A, 1'b0, 1'b0};
    tbl[8]  = '{1,  0, 0, -1, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b0};
    tbl[9]  = '{2,  5, 0, -1, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 16'h1357, 16'h2468, 1'b0, 1'b1};
    tbl[10] = '{0,  0, 0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1357, 16'h2468, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk_a, 0);
    chk("rst_lrck", lrck_a, 0);
    chk("rst_sdata", sd_a, 0);
    chk("rst_frame_start", fs_a, 0);
    chk("rst_underrun", ur_a, 0);
    chk("rst_overrun", or_a, 0);
    rst_a = 1'b0;

    // Table-driven frame scenarios.
    for (int j = 0; j < 11; j++) begin
      if (tbl[j].clr_off >= 0) pulse(ld(j) - tbl[j].clr_off, 1'b1, '0, '0);
      if (tbl[j].n >= 1) pulse(ld(j) - tbl[j].off_a, 1'b0, tbl[j].la, tbl[j].ra);
      if (tbl[j].n >= 2) pulse(ld(j) - tbl[j].off_b, 1'b0, tbl[j].lb, tbl[j].rb);
      while (cyc_a < ld(j)) @(negedge clk);
      chk($sformatf("tbl%0d_underrun", j), ur_a, tbl[j].xu);
      chk($sformatf("tbl%0d_overrun", j), or_a, tbl[j].xo);
    end

    // Randomised strobes against the interval model.
    for (int e = ld(10) + 1; e <= ld(20); e++) begin
      int r;
      while (cyc_a < e - 1) @(negedge clk);
      r = $urandom_range(0, 49);
      if (r == 0) pulse(e, 1'b0, AW'($urandom), AW'($urandom));
      else if (r == 1) pulse(e, 1'b1, '0, '0);
      else @(negedge clk);
      if (interval_of(e) * 4 * AD * AS + ld(0) == e) begin
        chk($sformatf("rnd_underrun_e%0d", e), ur_a, model_flag(1'b0, e));
        chk($sformatf("rnd_overrun_e%0d", e), or_a, model_flag(1'b1, e));
      end
    end
    while (cyc_a < ld(21) + 4) @(negedge clk);
    chk("a_frame_count", fa_l.size() >= 21, 1);
    if (fa_l.size() >= 21) begin
      for (int j = 0; j < 11; j++) begin
        chk($sformatf("tbl%0d_left", j), fa_l[j], {16'h0, tbl[j].xl});
        chk($sformatf("tbl%0d_right", j), fa_r[j], {16'h0, tbl[j].xr});
      end
      for (int j = 0; j < 21; j++) begin
        mf = model_frame(j);
        chk($sformatf("model%0d_frame", j), {fa_l[j][15:0], fa_r[j][15:0]}, mf);
      end
    end

    // Reset in the middle of a right slot, then restart.
    while (cyc_a < ld(22) + 40) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_bclk", bclk_a, 0);
    chk("mid_rst_lrck", lrck_a, 0);
    chk("mid_rst_sdata", sd_a, 0);
    chk("mid_rst_frame_start", fs_a, 0);
    chk("mid_rst_underrun", ur_a, 0);
    chk("mid_rst_overrun", or_a, 0);
    ev_edge.delete(); ev_l.delete(); ev_r.delete(); clr_edge.delete();
    @(negedge clk);
    rst_a = 1'b0;
    pulse(1, 1'b0, 16'hBEEF, 16'h0123);
    chk("restart_e1_bclk", bclk_a, 1);
    chk("restart_e1_frame_start", fs_a, 0);
    @(negedge clk);
    chk("restart_e2_frame_start", fs_a, 1);
    chk("restart_e2_sdata", sd_a, 1);
    chk("restart_e2_lrck", lrck_a, 0);
    while (cyc_a < ld(2) + 4) @(negedge clk);
    chk("restart_frames", fa_l.size() >= 2, 1);
    if (fa_l.size() >= 2) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("restart%0d_left", j), fa_l[j], 32'h0000BEEF);
        chk($sformatf("restart%0d_right", j), fa_r[j], 32'h00000123);
        mf = model_frame(j);
        chk($sformatf("restart%0d_model", j), {fa_l[j][15:0], fa_r[j][15:0]}, mf);
      end
    end
    chk("restart_underrun", ur_a, 1);
    chk("restart_overrun", or_a, 0);
    rst_a = 1'b1;

    // Wide sample in a wider slot, BCLK_DIV=2.
    rst_b = 1'b0;
    @(negedge clk);
    sv_b = 1'b1; l_b = 24'h123456; r_b = 24'hABCDEF;
    @(negedge clk);
    sv_b = 1'b0;
    while (cyc_b < 4 + 256 * 2 + 8) @(negedge clk);
    chk("b_frames", fb_l.size() >= 2, 1);
    if (fb_l.size() >= 2) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("b%0d_left", j), fb_l[j], 32'h12345600);
        chk($sformatf("b%0d_right", j), fb_r[j], 32'hABCDEF00);
      end
    end
    chk("b_lrck_fall_seen", lrfall_b.size() >= 1, 1);
    chk("b_fs_seen", fsb.size() >= 2, 1);
    if (lrfall_b.size() >= 1 && fsb.size() >= 2) begin
      chk("b_first_load", fsb[0], 4);
      chk("b_lrck_fall", lrfall_b[0], 256);
      chk("b_lrck_lead", fsb[1] - lrfall_b[0], 2 * BD);
    end
    chk("b_underrun", ur_b, 1);
    chk("b_overrun", or_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
